lock_entry_controller: RTL and testbench
========================================

// Module: lock_entry_controller
// PURPOSE
//  Sequencer in front of the 3-digit combination-lock Moore FSM. Turns raw keypad presses into
//  single-cycle enter/correct_digit strokes for the FSM. Holds the secret code (loadable while open),
//  tracks digit position, counts failed attempts, enforces a lockout and aborts stale partial entries.
//  Sits between keypad/debounce logic and the lock FSM; FSM enter/correct_digit are driven only here.
// PARAMETERS
//  DEFAULT_CODE    12'h123  code after reset; {d0,d1,d2}, d0 in [11:8] is entered first
//  MAX_FAILS       3        wrong-digit events that trigger lockout (>=1)
//  LOCKOUT_CYCLES  1000     clk cycles of lockout (>=1)
//  TIMEOUT_CYCLES  500      idle cycles before a partial entry is aborted (>=1)
// PORTS
//  clk            in   1   system clock, all logic on rising edge
//  reset          in   1   synchronous, active-high
//  key_press      in   1   debounced level, high while a key is held
//  key_digit      in   4   digit of held key, valid while key_press=1
//  code_in        in   12  new code {d0,d1,d2}
//  code_load      in   1   1-cycle strobe, loads code_in (honoured only in OPEN)
//  enter          out  1   1-cycle stroke to lock FSM
//  correct_digit  out  1   qualifier to lock FSM, valid when enter=1, else 0
//  lockout        out  1   high during lockout
//  fail_count     out  2   wrong digits since last clear (saturates at MAX_FAILS)
//  digit_idx      out  2   digits accepted so far (0..2 entering, 3 = open)
// BEHAVIOUR
//  - Reset (sync): state=ENTRY, digit_idx=0, fail_count=0, code=DEFAULT_CODE, all outputs 0, timers 0,
//    key edge register cleared (a key held through reset does NOT count until released and re-pressed).
//  - Press event = rising edge of key_press (key_press & ~key_press_q). One event per press.
//  - States: ENTRY, OPEN, LOCKOUT. Stroke latency: enter/correct_digit registered, high the cycle after
//    the edge is sampled; never high two consecutive cycles.
//  - ENTRY, press: match = (key_digit == code digit[digit_idx]).
//      match: stroke(enter=1,correct=1); digit_idx+1; digit_idx 2->3 => OPEN, fail_count=0.
//      mismatch: stroke(enter=1,correct=0); digit_idx=0; fail_count+1; if it reaches MAX_FAILS => LOCKOUT.
//  - ENTRY, idle timer: counts cycles without a press while digit_idx in 1..2; reaching TIMEOUT_CYCLES
//    emits abort stroke(enter=1,correct=0), digit_idx=0, fail_count unchanged. Timer held 0 at digit_idx=0;
//    cleared by every press. Press and expiry in same cycle: press wins, no abort.
//  - OPEN: any press emits stroke(enter=1,correct=0) (FSM relocks), digit_idx=0 -> ENTRY. code_load copies
//    code_in into code next cycle; code_load together with a relock press: both take effect.
//    code_load outside OPEN ignored. No timeout in OPEN.
//  - LOCKOUT: lockout=1, presses ignored (edge register still tracks), no strokes; counter runs
//    LOCKOUT_CYCLES then -> ENTRY, fail_count=0, lockout=0 the following cycle.
//  - Counters sized $clog2(max(LOCKOUT_CYCLES,TIMEOUT_CYCLES)+1); no wrap, compare for equality.
//  - Reset mid-lockout or mid-entry: immediate return to reset values; code reverts to DEFAULT_CODE.
// STRUCTURE
//  - Shared package lock_pkg: state encoding (ENTRY/OPEN/LOCKOUT), DIGITS=3, DIGIT_W=4, code type.
//  - One sub-module: lock_cycle_timer (load/run/expire counter) reused for idle timeout and lockout.
//  - Edge detect, code register, idx/fail logic and stroke regs inline.
// TESTING
//  - Reset; press 1,2,3 -> three strokes correct=1, digit_idx=3, FSM state 3, fail_count 0.
//  - Press 1,5 -> 2nd stroke correct=0, digit_idx=0, fail_count=1; then 1,2,3 opens, fail_count=0.
//  - Three wrong digits (MAX_FAILS=3) -> lockout=1 for exactly 1000 cycles; press 1,2,3 inside: no strokes.
//  - Press 1, idle 500 cycles -> one abort stroke correct=0, digit_idx=0, fail_count still 0.
//  - OPEN, code_load 12'h987, press any -> relock; 1,2,3 fails, 9,8,7 opens.
//  - Key held across reset release -> no stroke; assert reset during LOCKOUT -> lockout=0 next cycle.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock entry sequencer:
// state encoding, code geometry and digit extraction.
package lock_pkg;

  localparam int DIGITS  = 3;
  localparam int DIGIT_W = 4;
  localparam int CODE_W  = DIGITS * DIGIT_W;

  localparam logic [1:0] ST_ENTRY   = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  typedef logic [CODE_W-1:0]  code_t;
  typedef logic [DIGIT_W-1:0] digit_t;

  // Digit 0 sits in the most significant nibble and is entered first.
  function automatic digit_t code_digit(input code_t code, input logic [1:0] idx);
    digit_t d;
    d = code[CODE_W-1 -: DIGIT_W];
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 2'(i)) d = code[CODE_W-1-DIGIT_W*i -: DIGIT_W];
    end
    return d;
  endfunction

endpackage

// File: rtl/lock_cycle_timer.sv
// Cycle counter that runs while run_i is high and pulses expire_o on the
// LIMIT-th consecutive running cycle; dropping run_i restarts it from zero.
module lock_cycle_timer #(
  parameter int WIDTH = 10,
  parameter int LIMIT = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic expire_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign expire_o = run_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || expire_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lock_entry_controller.sv
// Keypad-to-lock-FSM sequencer: turns key presses into single-cycle enter
// strokes, tracks digit position and failures, and handles timeout/lockout.
module lock_entry_controller
  import lock_pkg::*;
#(
  parameter code_t DEFAULT_CODE   = 12'h123,
  parameter int    MAX_FAILS      = 3,
  parameter int    LOCKOUT_CYCLES = 1000,
  parameter int    TIMEOUT_CYCLES = 500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_press,
  input  logic [DIGIT_W-1:0] key_digit,
  input  code_t              code_in,
  input  logic               code_load,
  output logic               enter,
  output logic               correct_digit,
  output logic               lockout,
  output logic [1:0]         fail_count,
  output logic [1:0]         digit_idx
);

  localparam int CNT_MAX = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [1:0] FAIL_LIMIT = 2'(MAX_FAILS);
  localparam logic [1:0] LAST_IDX   = 2'(DIGITS - 1);
  localparam logic [1:0] OPEN_IDX   = 2'(DIGITS);

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] fail_q, fail_d;
  code_t      code_q, code_d;
  logic       enter_q, enter_d;
  logic       correct_q, correct_d;
  logic       key_q;
  logic       press_evt;
  logic       idle_run, idle_expire;
  logic       lock_run, lock_expire;

  assign press_evt = key_press && !key_q;

  assign idle_run = (state_q == ST_ENTRY) && (idx_q != 2'd0) && !press_evt;
  assign lock_run = (state_q == ST_LOCKOUT);

  lock_cycle_timer #(.WIDTH(CNT_W), .LIMIT(TIMEOUT_CYCLES)) u_idle_timer (
    .clk      (clk),
    .reset    (reset),
    .run_i    (idle_run),
    .expire_o (idle_expire)
  );

  lock_cycle_timer #(.WIDTH(CNT_W), .LIMIT(LOCKOUT_CYCLES)) u_lock_timer (
    .clk      (clk),
    .reset    (reset),
    .run_i    (lock_run),
    .expire_o (lock_expire)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fail_d    = fail_q;
    code_d    = code_q;
    enter_d   = 1'b0;
    correct_d = 1'b0;

    if (state_q == ST_OPEN && code_load) code_d = code_in;

    case (state_q)
      ST_ENTRY: begin
        if (press_evt) begin
          enter_d = 1'b1;
          if (key_digit == code_digit(code_q, idx_q)) begin
            correct_d = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d   = OPEN_IDX;
              fail_d  = 2'd0;
              state_d = ST_OPEN;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            idx_d = 2'd0;
            if (fail_q + 2'd1 == FAIL_LIMIT) begin
              fail_d  = FAIL_LIMIT;
              state_d = ST_LOCKOUT;
            end else begin
              fail_d = fail_q + 2'd1;
            end
          end
        end else if (idle_expire) begin
          // Stale partial entry: a wrong-qualified stroke resets the FSM without counting a failure.
          enter_d = 1'b1;
          idx_d   = 2'd0;
        end
      end
      ST_OPEN: begin
        if (press_evt) begin
          enter_d = 1'b1;
          idx_d   = 2'd0;
          state_d = ST_ENTRY;
        end
      end
      ST_LOCKOUT: begin
        if (lock_expire) begin
          fail_d  = 2'd0;
          state_d = ST_ENTRY;
        end
      end
      default: begin
        idx_d   = 2'd0;
        state_d = ST_ENTRY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ENTRY;
      idx_q     <= 2'd0;
      fail_q    <= 2'd0;
      code_q    <= DEFAULT_CODE;
      enter_q   <= 1'b0;
      correct_q <= 1'b0;
      // Treated as held so a key kept down through reset needs a release first.
      key_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fail_q    <= fail_d;
      code_q    <= code_d;
      enter_q   <= enter_d;
      correct_q <= correct_d;
      key_q     <= key_press;
    end
  end

  assign enter         = enter_q;
  assign correct_digit = correct_q;
  assign lockout       = (state_q == ST_LOCKOUT);
  assign fail_count    = fail_q;
  assign digit_idx     = idx_q;

endmodule

// File: tb/tb_lock_entry_controller.sv
// Directed bench for lock_entry_controller: code entry, relock, code load,
// idle abort, lockout and reset behaviour with default parameters.
module tb_lock_entry_controller;

  logic        clk;
  logic        reset;
  logic        key_press;
  logic [3:0]  key_digit;
  logic [11:0] code_in;
  logic        code_load;
  logic        enter;
  logic        correct_digit;
  logic        lockout;
  logic [1:0]  fail_count;
  logic [1:0]  digit_idx;

  int n_asserts = 0;
  int n_fail    = 0;

  lock_entry_controller #(
    .DEFAULT_CODE   (12'h123),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (1000),
    .TIMEOUT_CYCLES (500)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_press     (key_press),
    .key_digit     (key_digit),
    .code_in       (code_in),
    .code_load     (code_load),
    .enter         (enter),
    .correct_digit (correct_digit),
    .lockout       (lockout),
    .fail_count    (fail_count),
    .digit_idx     (digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cyc();
    reset = 1'b0;
    cyc();
  endtask

  // One press: key high for one cycle, then low one cycle; checks the stroke.
  task automatic press(input string tag, input logic [3:0] d, input logic exp_corr);
    key_digit = d;
    key_press = 1'b1;
    cyc();
    chk({tag, "_enter"}, 32'(enter), 32'd1);
    chk({tag, "_correct"}, 32'(correct_digit), 32'(exp_corr));
    key_press = 1'b0;
    cyc();
    chk({tag, "_single"}, 32'(enter), 32'd0);
    $display("press %s digit=%0h enter=1 correct=%0b idx=%0d fails=%0d", tag, d, exp_corr, digit_idx, fail_count);
  endtask

  int n_str, abort_at, n_lock;
  logic ab_corr;

  initial begin
    reset = 1'b1; key_press = 1'b0; key_digit = 4'h0; code_in = 12'h000; code_load = 1'b0;

    // Reset state
    do_reset(3);
    chk("rst_enter", 32'(enter), 32'd0);
    chk("rst_correct", 32'(correct_digit), 32'd0);
    chk("rst_lockout", 32'(lockout), 32'd0);
    chk("rst_fail", 32'(fail_count), 32'd0);
    chk("rst_idx", 32'(digit_idx), 32'd0);

    // Correct code opens
    press("c1", 4'h1, 1'b1);
    chk("c1_idx", 32'(digit_idx), 32'd1);
    press("c2", 4'h2, 1'b1);
    press("c3", 4'h3, 1'b1);
    chk("open_idx", 32'(digit_idx), 32'd3);
    chk("open_fail", 32'(fail_count), 32'd0);

    // Relock from OPEN
    press("relock1", 4'h5, 1'b0);
    chk("relock1_idx", 32'(digit_idx), 32'd0);

    // Wrong second digit, then reopen clears the fail count
    press("w1", 4'h1, 1'b1);
    press("w2", 4'h5, 1'b0);
    chk("w2_idx", 32'(digit_idx), 32'd0);
    chk("w2_fail", 32'(fail_count), 32'd1);
    press("r1", 4'h1, 1'b1);
    press("r2", 4'h2, 1'b1);
    press("r3", 4'h3, 1'b1);
    chk("reopen_idx", 32'(digit_idx), 32'd3);
    chk("reopen_fail", 32'(fail_count), 32'd0);

    // Code load together with relock press
    key_digit = 4'h0; key_press = 1'b1; code_in = 12'h987; code_load = 1'b1;
    cyc();
    code_load = 1'b0;
    chk("load_relock_enter", 32'(enter), 32'd1);
    chk("load_relock_correct", 32'(correct_digit), 32'd0);
    chk("load_relock_idx", 32'(digit_idx), 32'd0);
    key_press = 1'b0;
    cyc();
    // code_load outside OPEN must be ignored
    code_in = 12'h456; code_load = 1'b1;
    cyc();
    code_load = 1'b0;
    press("old1", 4'h1, 1'b0);
    chk("old1_fail", 32'(fail_count), 32'd1);
    press("n1", 4'h9, 1'b1);
    press("n2", 4'h8, 1'b1);
    press("n3", 4'h7, 1'b1);
    chk("newcode_idx", 32'(digit_idx), 32'd3);
    chk("newcode_fail", 32'(fail_count), 32'd0);
    // Restore 123 in OPEN, then relock
    code_in = 12'h123; code_load = 1'b1;
    cyc();
    code_load = 1'b0;
    press("relock2", 4'h0, 1'b0);

    // Idle timeout: abort stroke 500 cycles after the press stroke
    key_digit = 4'h1; key_press = 1'b1;
    cyc();
    key_press = 1'b0;
    chk("to_press_enter", 32'(enter), 32'd1);
    chk("to_press_idx", 32'(digit_idx), 32'd1);
    n_str = 0; abort_at = 0; ab_corr = 1'b1;
    for (int k = 1; k <= 520; k++) begin
      cyc();
      if (enter) begin
        n_str++;
        abort_at = k;
        ab_corr = correct_digit;
      end
      if (k == 490) chk("to_idx_hold", 32'(digit_idx), 32'd1);
    end
    chk("to_strokes", 32'(n_str), 32'd1);
    chk("to_cycle", 32'(abort_at), 32'd500);
    chk("to_correct", 32'(ab_corr), 32'd0);
    chk("to_idx", 32'(digit_idx), 32'd0);
    chk("to_fail", 32'(fail_count), 32'd0);
    $display("timeout abort at cycle %0d strokes=%0d", abort_at, n_str);

    // Three wrong digits -> lockout for exactly 1000 cycles, presses ignored
    press("l1", 4'h7, 1'b0);
    press("l2", 4'h7, 1'b0);
    key_digit = 4'h7; key_press = 1'b1;
    cyc();
    key_press = 1'b0;
    chk("l3_enter", 32'(enter), 32'd1);
    chk("l3_correct", 32'(correct_digit), 32'd0);
    chk("l3_lockout", 32'(lockout), 32'd1);
    chk("l3_fail", 32'(fail_count), 32'd3);
    n_lock = 1; n_str = 0;
    for (int k = 1; k <= 1100; k++) begin
      if (k == 100) begin key_digit = 4'h1; key_press = 1'b1; end
      if (k == 103) begin key_digit = 4'h2; key_press = 1'b1; end
      if (k == 106) begin key_digit = 4'h3; key_press = 1'b1; end
      if (k == 101 || k == 104 || k == 107) key_press = 1'b0;
      cyc();
      if (lockout) n_lock++;
      if (enter) n_str++;
      if (k == 500) chk("lk_fail_hold", 32'(fail_count), 32'd3);
    end
    chk("lk_cycles", 32'(n_lock), 32'd1000);
    chk("lk_strokes", 32'(n_str), 32'd0);
    chk("lk_fail_clear", 32'(fail_count), 32'd0);
    chk("lk_idx", 32'(digit_idx), 32'd0);
    $display("lockout cycles=%0d strokes=%0d", n_lock, n_str);
    press("post1", 4'h1, 1'b1);

    // Key held across reset release: no stroke until re-pressed
    key_digit = 4'h1; key_press = 1'b1;
    do_reset(2);
    n_str = 0;
    for (int k = 0; k < 5; k++) begin
      if (enter) n_str++;
      cyc();
    end
    chk("held_strokes", 32'(n_str), 32'd0);
    chk("held_idx", 32'(digit_idx), 32'd0);
    key_press = 1'b0;
    cyc();
    press("held_re", 4'h1, 1'b1);

    // Loaded code reverts to default after reset
    press("d2", 4'h2, 1'b1);
    press("d3", 4'h3, 1'b1);
    code_in = 12'h987; code_load = 1'b1;
    cyc();
    code_load = 1'b0;
    do_reset(1);
    press("def1", 4'h1, 1'b1);
    press("def2", 4'h2, 1'b1);
    press("def3", 4'h3, 1'b1);
    chk("default_idx", 32'(digit_idx), 32'd3);

    // Reset during lockout
    do_reset(1);
    press("m1", 4'h5, 1'b0);
    press("m2", 4'h5, 1'b0);
    press("m3", 4'h5, 1'b0);
    repeat (10) cyc();
    chk("mid_lockout", 32'(lockout), 32'd1);
    reset = 1'b1;
    cyc();
    chk("rstlk_lockout", 32'(lockout), 32'd0);
    chk("rstlk_fail", 32'(fail_count), 32'd0);
    chk("rstlk_idx", 32'(digit_idx), 32'd0);
    chk("rstlk_enter", 32'(enter), 32'd0);
    reset = 1'b0;
    cyc();
    press("after_rst", 4'h1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
